// File: rtl/if_fetch_pkg.sv
// Shared widths, reset/enable constants and the IF/ID record for the fetch stage.
package if_fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [INST_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] INST_STEP    = 32'd4;
  localparam logic              CHIP_ENABLE  = 1'b1;
  localparam logic              CHIP_DISABLE = 1'b0;
  localparam logic              RST_ENABLE   = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;
    logic              adel;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: ZERO_WORD, inst: ZERO_WORD, valid: 1'b0, adel: 1'b0};

  function automatic logic misaligned(input logic [ADDR_W-1:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/if_fetch_if_id_reg.sv
// IF/ID pipeline register: bubbles on flush or IF-only stall, holds on ID stall, else captures.
module if_id_reg
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_stall_if,
  input  logic              i_stall_id,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ce,
  input  logic [INST_W-1:0] i_inst,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [INST_W-1:0] o_id_inst,
  output logic              o_id_valid,
  output logic              o_id_adel
);
  if_id_t r_id;
  if_id_t w_capture;
  logic   w_adel;

  always_comb begin
    w_adel          = misaligned(i_pc);
    w_capture.pc    = i_pc;
    w_capture.valid = i_ce;
    w_capture.adel  = w_adel;
    // never forward ROM data for a misaligned or disabled fetch
    w_capture.inst  = (w_adel || i_ce == CHIP_DISABLE) ? ZERO_WORD : i_inst;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_id <= IF_ID_BUBBLE;
    end else if (i_flush || (i_stall_if && !i_stall_id)) begin
      r_id <= IF_ID_BUBBLE;
    end else if (!i_stall_id) begin
      r_id <= w_capture;
    end
  end

  assign o_id_pc    = r_id.pc;
  assign o_id_inst  = r_id.inst;
  assign o_id_valid = r_id.valid;
  assign o_id_adel  = r_id.adel;
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC sequencing with flush/stall/branch priority and a one-entry
// pending branch that survives an IF stall; feeds the IF/ID register one cycle later.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic              id_adel_o
);
  logic              r_ce;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc + INST_STEP;
    if (flush)              w_pc_next = new_pc;
    else if (stall_if)      w_pc_next = r_pc;
    else if (r_pend_valid)  w_pc_next = r_pend_target;
    else if (branch_flag_i) w_pc_next = branch_target_i;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_ce <= CHIP_DISABLE;
      r_pc <= RESET_VECTOR;
    end else begin
      r_ce <= CHIP_ENABLE;
      // PC stays at the reset vector until the ROM has been enabled for one cycle
      r_pc <= (r_ce == CHIP_DISABLE) ? RESET_VECTOR : w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= ZERO_WORD;
    end else if (flush) begin
      r_pend_valid  <= 1'b0;
    end else if (stall_if && branch_flag_i) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= branch_target_i;
    end else if (!stall_if) begin
      r_pend_valid  <= 1'b0;
    end
  end

  assign rom_ce_o   = r_ce;
  assign rom_addr_o = r_pc;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_stall_if (stall_if),
    .i_stall_id (stall_id),
    .i_pc       (r_pc),
    .i_ce       (r_ce),
    .i_inst     (rom_inst_i),
    .o_id_pc    (id_pc_o),
    .o_id_inst  (id_inst_o),
    .o_id_valid (id_valid_o),
    .o_id_adel  (id_adel_o)
  );
endmodule
